// File: rtl/bht_update_unit.sv
// BHT write-side update unit: follows fetched conditional branches to execute,
// resolves their 2-bit predictions and drives the BHT write port plus statistics.
module bht_update_unit #(
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             f_valid,
  input  logic [31:0]      f_pc,
  input  logic [1:0]       f_pred,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  output logic             write,
  output logic [31:0]      pc2,
  output logic [1:0]       updated_logic,
  output logic             mispredict,
  output logic             seq_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned PC_W   = 32;
  localparam int unsigned PRED_W = 2;
  localparam int unsigned TAIL   = PIPE_DEPTH - 1;

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [PRED_W-1:0] pred;
  } entry_t;

  entry_t              entries [PIPE_DEPTH];
  entry_t              tail_c;
  logic                resolve_c;
  logic                err_c;
  logic                mispred_c;
  logic [PRED_W-1:0]   next_c;

  assign tail_c = entries[TAIL];

  // Resolution match and saturating 2-bit counter next state
  always_comb begin
    resolve_c = ex_valid && !stall && tail_c.valid && (tail_c.pc == ex_pc);
    err_c     = ex_valid && !stall && !resolve_c;
    mispred_c = (tail_c.pred[1] != ex_taken);
    next_c    = tail_c.pred;
    if (ex_taken) begin
      if (tail_c.pred != 2'b11) next_c = tail_c.pred + PRED_W'(1);
    end else begin
      if (tail_c.pred != 2'b00) next_c = tail_c.pred - PRED_W'(1);
    end
  end

  // Tracking pipeline: flush clears valids even while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PIPE_DEPTH); i++) entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(PIPE_DEPTH); i++) entries[i].valid <= 1'b0;
    end else if (!stall) begin
      entries[0] <= '{valid: f_valid, pc: f_pc, pred: f_pred};
      for (int i = 1; i < int'(PIPE_DEPTH); i++) entries[i] <= entries[i-1];
    end
  end

  // Registered write port, pulses and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      write         <= 1'b0;
      pc2           <= '0;
      updated_logic <= '0;
      mispredict    <= 1'b0;
      seq_err       <= 1'b0;
      branch_cnt    <= '0;
      mispred_cnt   <= '0;
    end else begin
      write      <= resolve_c;
      mispredict <= resolve_c && mispred_c;
      seq_err    <= err_c;
      if (resolve_c) begin
        pc2           <= ex_pc;
        updated_logic <= next_c;
        branch_cnt    <= branch_cnt + CNT_W'(1);
        if (mispred_c) mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/bht_update_unit.md
Name: bht_update_unit

Overview:
- Write-side companion to the branch history table (BHT): tracks each fetched conditional branch and its 2-bit BHT prediction down the pipeline to execute.
- At execute, compares the prediction with the resolved outcome and computes the saturating-counter next state.
- Drives the BHT write port (write, pc2, updated_logic) and a mispredict pulse for the hazard/flush logic.
- Sits between the fetch-stage BHT read and the execute-stage branch comparator; also keeps branch/mispredict statistics counters.

Parameters:
- PIPE_DEPTH, 2, number of tracking entries between fetch and execute (fetch->decode->execute); legal values >= 1.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  pipeline freeze; tracking entries hold and no resolution occurs.
- flush  input  1  kill all in-flight tracked branches.
- f_valid  input  1  fetched instruction is a conditional branch (opcode 1100011), i.e. the BHT read strobe.
- f_pc  input  32  fetch-stage PC of that branch.
- f_pred  input  2  BHT prediction for f_pc; bit1=1 means predict taken.
- ex_valid  input  1  execute stage holds a resolved conditional branch.
- ex_pc  input  32  PC of the execute-stage branch.
- ex_taken  input  1  actual branch outcome.
- write  output  1  one-cycle BHT write strobe.
- pc2  output  32  PC to update in the BHT (execute PC).
- updated_logic  output  2  new 2-bit counter value.
- mispredict  output  1  one-cycle pulse, prediction direction wrong.
- seq_err  output  1  one-cycle pulse, ex_valid with no matching tracked entry.
- branch_cnt  output  CNT_W  resolved branches since reset.
- mispred_cnt  output  CNT_W  mispredicted branches since reset.

Behaviour:
- Reset (rst=1 at a clock edge): all entries invalid; write, mispredict, seq_err = 0; pc2 = 0; updated_logic = 0; both counters = 0. Reset overrides every other input in the same cycle. A resolution pending in that cycle is dropped.
- Tracking pipeline: PIPE_DEPTH entries of {valid, pc[31:0], pred[1:0]}.
  - When !stall && !flush: entry0 <= {f_valid, f_pc, f_pred} and entry[i] <= entry[i-1]. The tail entry (PIPE_DEPTH-1) is the execute-stage entry.
  - stall=1: all entries hold; f_* inputs are ignored.
  - flush=1 (and !stall): all valid bits cleared at the edge; f_* not captured. flush with stall: flush wins.
- Resolution condition R = ex_valid && !stall && tail.valid && tail.pc == ex_pc. R is evaluated in the same cycle as flush (the execute-stage branch still resolves).
- Counter rule, states 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T:
  - ex_taken=1: next = (pred==11) ? 11 : pred+1.
  - ex_taken=0: next = (pred==00) ? 00 : pred-1.
  - No wrap at either end.
- Outputs are registered with 1-cycle latency after R:
  - write=1, pc2=ex_pc, updated_logic=next, mispredict=(tail.pred[1] != ex_taken).
  - In cycles without R: write=0 and mispredict=0; pc2 and updated_logic hold their last values.
- Error case: ex_valid && !stall && !R gives seq_err=1 next cycle; write=0; counters unchanged.
- Counters:
  - On R: branch_cnt +1; mispred_cnt +1 if mispredict.
  - Both wrap modulo 2^CNT_W. They update in the same edge as the registered outputs.
- Back-to-back resolutions are supported with one write per cycle and no bubbles.
- stall held with ex_valid: no write until stall drops; exactly one write per branch.

Test Plan:
- Basic: f_valid=1, f_pc=0x100, f_pred=01 at cycle 0; ex_valid=1, ex_pc=0x100, ex_taken=1 at cycle 2 -> cycle 3: write=1, pc2=0x100, updated_logic=10, mispredict=1, branch_cnt=1, mispred_cnt=1.
- Saturation:
  - pred 11, taken -> updated_logic=11, mispredict=0.
  - pred 00, not taken -> updated_logic=00, mispredict=0.
  - pred 10, not taken -> updated_logic=01, mispredict=1.
- Stall: branch 0x140 at tail, ex_valid held, stall=1 for 3 cycles -> write=0 throughout; stall drops -> exactly one write (pc2=0x140) the next cycle; branch_cnt +1 only.
- Flush: branches 0x200/0x204 in flight, flush=1 for one cycle -> later ex_valid with ex_pc=0x200 gives seq_err=1, write=0, counters unchanged.
- Back-to-back: 0x300 (pred 10) and 0x304 (pred 01) fetched consecutively, resolved not-taken then taken -> writes on consecutive cycles: (0x300, 01, mispredict=1) then (0x304, 10, mispredict=1); mispred_cnt=2.
- Reset mid-operation: rst=1 in the cycle R holds for 0x400 -> next cycle write=0, counters=0, all entries invalid; a following ex_valid=1 gives seq_err=1.
